if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_VECTOR, default 32'hBFC0_0000, address of the first instruction fetched after reset.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset, with ports as follows:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- stall  in  `StallBus  per-stage stall vector; bit 0 (`Stop = 1) freezes this stage
- br_bus  in  `BR_WD (33)  {br_e, br_addr[31:0]} from decode
- if_to_id_bus  out  `IF_TO_ID_WD (33)  {ce, pc[31:0]} to decode
- inst_sram_en  out  1  instruction SRAM read enable
- inst_sram_wen  out  4  SRAM byte write enables, constant 4'b0000
- inst_sram_addr  out  32  fetch address
- inst_sram_wdata  out  32  constant 32'b0
- redirect_pending  out  1  a branch redirect is latched and waiting for the stall to clear
- if_excp_adel  out  1  fetch address misaligned (see Configuration)

Function
REQ-003 pc_reg and ce_reg SHALL be state registers, with if_to_id_bus = {ce_reg, pc_reg}, inst_sram_addr = pc_reg and inst_sram_en = ce_reg (gated by REQ-015).
REQ-004 next_pc SHALL be selected by priority:
- pend_valid -> pend_addr
- else br_e -> br_addr
- else pc_reg + 4 (32-bit wrap, carry discarded)
REQ-005 On each rising edge with stall[0] = NoStop, the block SHALL load pc_reg <= next_pc and ce_reg <= 1, then clear pend_valid.
REQ-006 On each rising edge with stall[0] = Stop, pc_reg and ce_reg SHALL hold.
- If br_e = 1 and pend_valid = 0 in that cycle, the block SHALL set pend_valid <= 1 and pend_addr <= br_addr.
REQ-007 While pend_valid = 1, further br_e pulses SHALL be ignored: the first redirect wins, because decode is frozen and cannot legally issue a second branch.
REQ-008 The block SHALL implement a state machine with these states and transitions:
- BOOT: after reset, ce_reg = 0; moves to RUN on the first unstalled edge.
- RUN: moves to HOLD when stall[0] = Stop and br_e = 0.
- RUN: moves to HOLD_BR when stall[0] = Stop and br_e = 1.
- HOLD: moves to HOLD_BR when br_e = 1 while still stalled.
- HOLD: moves to RUN on unstall.
- HOLD_BR: moves to RUN on unstall, fetching pend_addr.
REQ-009 redirect_pending SHALL equal pend_valid, i.e. be 1 exactly in HOLD_BR.
REQ-010 br_e asserted in the same cycle as the stall releases (stall[0] = NoStop, pend_valid = 0) SHALL redirect in that edge with zero lost cycles.
REQ-011 Redirect latency SHALL be one edge: a br_e sampled at edge N makes inst_sram_addr = br_addr after edge N, unless stalled.
REQ-012 inst_sram_wen and inst_sram_wdata SHALL be constant zero in every state.

Reset
REQ-013 When rst = 1, the block SHALL asynchronously force:
- pc_reg = RESET_VECTOR - 4
- ce_reg = 0, pend_valid = 0, pend_addr = 0
- state = BOOT
- inst_sram_en = 0, redirect_pending = 0, if_excp_adel = 0
REQ-014 After rst is deasserted, the first unstalled edge SHALL give pc_reg = RESET_VECTOR and ce_reg = 1. A rst asserted mid-stall or while in HOLD_BR SHALL discard the pending redirect.

Configuration
REQ-015 With macro IF_ADEL_CHECK_EN defined:
- if_excp_adel SHALL be ce_reg & (pc_reg[1:0] != 0).
- inst_sram_en SHALL be 0 while if_excp_adel = 1.
- The PC SHALL otherwise keep advancing per REQ-004.
REQ-016 Without IF_ADEL_CHECK_EN, if_excp_adel SHALL be tied to 0, inst_sram_en SHALL equal ce_reg, and no check logic SHALL be instantiated.

Verification
REQ-017 Release rst with no stall -> after edge 1, if_to_id_bus = {1, BFC00000}, inst_sram_en = 1; after edge 2, pc = BFC00004.
REQ-018 pc = BFC00010, br_bus = {1, BFC00100} for one cycle, no stall -> next pc = BFC00100, then BFC00104.
REQ-019 stall[0] = 1 for 3 cycles with br_bus = {1, 80000040} in the first stalled cycle and {1, 80000080} in the second -> pc holds, redirect_pending = 1; on unstall pc = 80000040 and redirect_pending = 0.
REQ-020 Unstall cycle coincides with br_bus = {1, BFC00200}, pend_valid = 0 -> pc = BFC00200 at that edge.
REQ-021 Assert rst while in HOLD_BR, then release -> the pending address is lost and the first fetch is BFC00000.
REQ-022 With IF_ADEL_CHECK_EN defined, br_bus = {1, BFC00102} -> if_excp_adel = 1 and inst_sram_en = 0 for that fetch; without the macro, if_excp_adel stays 0.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch PC generator; optional misaligned-fetch check under IF_ADEL_CHECK_EN.
// Latency: one edge from next_pc (sequential, branch or pending redirect) to inst_sram_addr.
// Backpressure: stall[0] freezes pc/ce and latches the first branch until the stall clears.
`ifndef StallBus
`define StallBus 5:0
`endif
`ifndef Stop
`define Stop 1'b1
`endif
`ifndef NoStop
`define NoStop 1'b0
`endif
`ifndef BR_WD
`define BR_WD 33
`endif
`ifndef IF_TO_ID_WD
`define IF_TO_ID_WD 33
`endif

module if_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [`StallBus]        stall,
  input  logic [`BR_WD-1:0]       br_bus,
  output logic [`IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic                    inst_sram_en,
  output logic [3:0]              inst_sram_wen,
  output logic [31:0]             inst_sram_addr,
  output logic [31:0]             inst_sram_wdata,
  output logic                    redirect_pending,
  output logic                    if_excp_adel
);

  localparam logic [1:0] BOOT    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;
  localparam logic [1:0] HOLD_BR = 2'd3;

  logic [1:0]  state, state_nxt;
  logic [31:0] pc_reg, next_pc, pend_addr;
  logic        ce_reg, pend_valid, stop, br_e;
  logic [31:0] br_addr;
  logic        unused_stall;

  assign stop         = (stall[0] == `Stop);
  assign br_e         = br_bus[32];
  assign br_addr      = br_bus[31:0];
  assign unused_stall = ^stall[`StallBus];

  // A latched redirect outranks a live branch: decode was frozen when it arrived.
  always_comb begin
    next_pc = pc_reg + 32'd4;
    if (pend_valid)
      next_pc = pend_addr;
    else if (br_e)
      next_pc = br_addr;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    if (!stop) state_nxt = RUN; else if (br_e) state_nxt = HOLD_BR;
      RUN:     if (stop) state_nxt = br_e ? HOLD_BR : HOLD;
      HOLD:    if (!stop) state_nxt = RUN; else if (br_e) state_nxt = HOLD_BR;
      HOLD_BR: if (!stop) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg     <= RESET_VECTOR - 32'd4;
      ce_reg     <= 1'b0;
      pend_valid <= 1'b0;
      pend_addr  <= 32'd0;
      state      <= BOOT;
    end else begin
      state <= state_nxt;
      if (!stop) begin
        pc_reg     <= next_pc;
        ce_reg     <= 1'b1;
        pend_valid <= 1'b0;
      end else if (br_e && !pend_valid) begin
        pend_valid <= 1'b1;
        pend_addr  <= br_addr;
      end
    end
  end

  assign if_to_id_bus     = {ce_reg, pc_reg};
  assign inst_sram_addr   = pc_reg;
  assign inst_sram_wen    = 4'b0000;
  assign inst_sram_wdata  = 32'd0;
  assign redirect_pending = pend_valid;

`ifdef IF_ADEL_CHECK_EN
  assign if_excp_adel = ce_reg & (pc_reg[1:0] != 2'b00);
  assign inst_sram_en = ce_reg & ~if_excp_adel;
`else
  assign if_excp_adel = 1'b0;
  assign inst_sram_en = ce_reg;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed and randomized bench for if_fetch against a queue-based PC model.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = 6'd0;
  logic [32:0] br_bus = 33'd0;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        redirect_pending;
  logic        if_excp_adel;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: current fetch, enable, and at most one waiting redirect.
  logic [31:0] m_pc;
  logic        m_ce;
  logic [31:0] pend_q[$];

  if_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .br_bus           (br_bus),
    .if_to_id_bus     (if_to_id_bus),
    .inst_sram_en     (inst_sram_en),
    .inst_sram_wen    (inst_sram_wen),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_wdata  (inst_sram_wdata),
    .redirect_pending (redirect_pending),
    .if_excp_adel     (if_excp_adel)
  );

  always #5 clk = ~clk;

  function automatic logic exp_adel();
`ifdef IF_ADEL_CHECK_EN
    return m_ce && (m_pc[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, settle 1ns past it.
  task automatic step(input logic stop, input logic be, input logic [31:0] ba);
    stall  = {5'($urandom), stop};
    br_bus = {be, ba};
    @(posedge clk);
    if (!stop) begin
      if (pend_q.size() != 0) m_pc = pend_q.pop_front();
      else if (be)            m_pc = ba;
      else                    m_pc = m_pc + 32'd4;
      m_ce = 1'b1;
      pend_q.delete();
    end else if (be && pend_q.size() == 0) begin
      pend_q.push_back(ba);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    m_pc = 32'hBFC0_0000 - 32'd4;
    m_ce = 1'b0;
    pend_q.delete();
    n_total++;
    if ({if_to_id_bus, inst_sram_en, redirect_pending, if_excp_adel} !== {1'b0, 32'hBFBF_FFFC, 3'b000})
      $display("FAIL async_reset: got bus=%h en=%b pend=%b adel=%b, want bus=0bfbffffc en=0 pend=0 adel=0",
               if_to_id_bus, inst_sram_en, redirect_pending, if_excp_adel);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    stall = 6'd0; br_bus = 33'd0;
    do_reset();
    n_total++;
    if ({inst_sram_wen, inst_sram_wdata} !== 36'd0)
      $display("FAIL reset_wr_zero: got wen=%h wdata=%h, want 0", inst_sram_wen, inst_sram_wdata);
    else n_pass++;
    step(1'b1, 1'b0, 32'd0);
    n_total++;
    if ({if_to_id_bus, inst_sram_en} !== {1'b0, 32'hBFBF_FFFC, 1'b0})
      $display("FAIL boot_stalled: got bus=%h en=%b, want bus=0bfbffffc en=0", if_to_id_bus, inst_sram_en);
    else n_pass++;
  endtask

  task automatic test_boot();
    step(1'b0, 1'b0, 32'd0);
    n_total++;
    if ({if_to_id_bus, inst_sram_en} !== {1'b1, 32'hBFC0_0000, 1'b1})
      $display("FAIL boot_first: got bus=%h en=%b, want bus=1bfc00000 en=1", if_to_id_bus, inst_sram_en);
    else n_pass++;
    step(1'b0, 1'b0, 32'd0);
    n_total++;
    if (inst_sram_addr !== 32'hBFC0_0004)
      $display("FAIL boot_second: got pc=%h, want bfc00004", inst_sram_addr);
    else n_pass++;
  endtask

  task automatic test_branch();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0);
    n_total++;
    if (inst_sram_addr !== 32'hBFC0_0010)
      $display("FAIL seq_pc: got pc=%h, want bfc00010", inst_sram_addr);
    else n_pass++;
    step(1'b0, 1'b1, 32'hBFC0_0100);
    n_total++;
    if (inst_sram_addr !== 32'hBFC0_0100)
      $display("FAIL branch_target: got pc=%h, want bfc00100", inst_sram_addr);
    else n_pass++;
    step(1'b0, 1'b0, 32'd0);
    n_total++;
    if (inst_sram_addr !== 32'hBFC0_0104)
      $display("FAIL branch_next: got pc=%h, want bfc00104", inst_sram_addr);
    else n_pass++;
  endtask

  task automatic test_stall_redirect();
    step(1'b1, 1'b1, 32'h8000_0040);
    n_total++;
    if ({inst_sram_addr, redirect_pending} !== {32'hBFC0_0104, 1'b1})
      $display("FAIL stall_latch: got pc=%h pend=%b, want pc=bfc00104 pend=1", inst_sram_addr, redirect_pending);
    else n_pass++;
    step(1'b1, 1'b1, 32'h8000_0080);
    step(1'b1, 1'b0, 32'd0);
    n_total++;
    if ({inst_sram_addr, redirect_pending} !== {32'hBFC0_0104, 1'b1})
      $display("FAIL stall_hold: got pc=%h pend=%b, want pc=bfc00104 pend=1", inst_sram_addr, redirect_pending);
    else n_pass++;
    step(1'b0, 1'b0, 32'd0);
    n_total++;
    if ({inst_sram_addr, redirect_pending} !== {32'h8000_0040, 1'b0})
      $display("FAIL first_redirect_wins: got pc=%h pend=%b, want pc=80000040 pend=0", inst_sram_addr, redirect_pending);
    else n_pass++;
    step(1'b0, 1'b0, 32'd0);
    n_total++;
    if (inst_sram_addr !== 32'h8000_0044)
      $display("FAIL after_redirect: got pc=%h, want 80000044", inst_sram_addr);
    else n_pass++;
  endtask

  task automatic test_unstall_branch();
    step(1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'hBFC0_0200);
    n_total++;
    if ({inst_sram_addr, redirect_pending} !== {32'hBFC0_0200, 1'b0})
      $display("FAIL unstall_branch: got pc=%h pend=%b, want pc=bfc00200 pend=0", inst_sram_addr, redirect_pending);
    else n_pass++;
  endtask

  task automatic test_reset_in_hold_br();
    step(1'b1, 1'b1, 32'h8000_1000);
    n_total++;
    if (redirect_pending !== 1'b1)
      $display("FAIL hold_br_entry: got pend=%b, want 1", redirect_pending);
    else n_pass++;
    stall[0] = 1'b1;
    do_reset();
    step(1'b0, 1'b0, 32'd0);
    n_total++;
    if ({if_to_id_bus, redirect_pending} !== {1'b1, 32'hBFC0_0000, 1'b0})
      $display("FAIL reset_drops_pending: got bus=%h pend=%b, want bus=1bfc00000 pend=0", if_to_id_bus, redirect_pending);
    else n_pass++;
  endtask

  task automatic test_adel();
    step(1'b0, 1'b1, 32'hBFC0_0102);
    n_total++;
`ifdef IF_ADEL_CHECK_EN
    if ({if_excp_adel, inst_sram_en, inst_sram_addr} !== {2'b10, 32'hBFC0_0102})
      $display("FAIL adel_flag: got adel=%b en=%b pc=%h, want adel=1 en=0 pc=bfc00102", if_excp_adel, inst_sram_en, inst_sram_addr);
    else n_pass++;
`else
    if ({if_excp_adel, inst_sram_en, inst_sram_addr} !== {2'b01, 32'hBFC0_0102})
      $display("FAIL adel_flag: got adel=%b en=%b pc=%h, want adel=0 en=1 pc=bfc00102", if_excp_adel, inst_sram_en, inst_sram_addr);
    else n_pass++;
`endif
    step(1'b0, 1'b0, 32'd0);
    n_total++;
    if (inst_sram_addr !== 32'hBFC0_0106)
      $display("FAIL adel_advance: got pc=%h, want bfc00106", inst_sram_addr);
    else n_pass++;
    step(1'b0, 1'b1, 32'hBFC0_0300);
  endtask

  task automatic test_random();
    logic        stop, be;
    logic [31:0] ba;
    logic [36:0] want;
    for (int i = 0; i < 400; i++) begin
      stop = ($urandom_range(0, 2) == 0);
      be   = ($urandom_range(0, 3) == 0);
      ba   = $urandom;
      if ($urandom_range(0, 7) != 0) ba[1:0] = 2'b00;
      step(stop, be, ba);
      want = {m_ce, m_pc, m_ce && !exp_adel(), (pend_q.size() != 0), exp_adel(), 1'b0};
      n_total++;
      if ({if_to_id_bus, inst_sram_en, redirect_pending, if_excp_adel, |inst_sram_wen | |inst_sram_wdata} !== want)
        $display("FAIL random[%0d]: got bus=%h en=%b pend=%b adel=%b wr=%b, want bus=%h en=%b pend=%b adel=%b wr=0",
                 i, if_to_id_bus, inst_sram_en, redirect_pending, if_excp_adel,
                 |inst_sram_wen | |inst_sram_wdata, want[36:4], want[3], want[2], want[1]);
      else n_pass++;
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_boot();
    test_branch();
    test_stall_redirect();
    test_unstall_branch();
    test_reset_in_hold_br();
    test_adel();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
